// File: rtl/dpram_xfer_ctrl.sv
// FILL / COPY / CHECK sequencer for a two-port synchronous RAM with 1-cycle registered reads.
// Port A only reads; port B is never pointed at port A's address while it writes.
module dpram_xfer_ctrl #(
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned ADDR_WIDTH = 4,
   localparam int unsigned ADDR_DEPTH = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic [DATA_WIDTH-1:0] pattern,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   mismatch_cnt,
   output logic                  we1,
   output logic                  oe1,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] din_a,
   input  logic [DATA_WIDTH-1:0] dout_a,
   output logic                  we2,
   output logic                  oe2,
   output logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] din_b,
   input  logic [DATA_WIDTH-1:0] dout_b
);

   localparam logic [1:0] ModeFill = 2'b00;
   localparam logic [1:0] ModeCopy = 2'b01;
   localparam logic [1:0] ModeBad  = 2'b11;
   localparam logic [ADDR_WIDTH:0]   One     = 1;
   localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
   localparam logic [ADDR_WIDTH:0]   LenMax  = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

   typedef enum logic [3:0] {
      StIdle, StFill, StCopyP, StCopyDrain, StCopyRd, StCopyWr, StChk, StChkDrain, StDone
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   idx_q, idx_d, len_q, len_d, cnt_q;
   logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic [DATA_WIDTH-1:0] pat_q, pat_d;
   logic                  cmd_err_q, cmd_err_d;
   logic                  last, cmp_valid;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
   logic                  oe1_q, oe1_d, oe2_q, oe2_d, we2_q, we2_d, copy_wr_q, copy_wr_d;
   logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

   assign last      = (idx_q == len_q - One);
   assign cmp_valid = ((state_q == StChk) && (idx_q != '0)) || (state_q == StChkDrain);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         len_q     <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         pat_q     <= '0;
         cmd_err_q <= 1'b0;
         cnt_q     <= '0;
         oe1_q     <= 1'b0;
         oe2_q     <= 1'b0;
         we2_q     <= 1'b0;
         copy_wr_q <= 1'b0;
         addra_q   <= '1;
         addrb_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         pat_q     <= pat_d;
         cmd_err_q <= cmd_err_d;
         oe1_q     <= oe1_d;
         oe2_q     <= oe2_d;
         we2_q     <= we2_d;
         copy_wr_q <= copy_wr_d;
         addra_q   <= addra_d;
         addrb_q   <= addrb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         if ((state_q == StIdle) && start) begin
            cnt_q <= '0;
         end else if (cmp_valid && (dout_b != pat_q)) begin
            cnt_q <= cnt_q + One;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      src_d     = src_q;
      dst_d     = dst_q;
      pat_d     = pat_q;
      cmd_err_d = cmd_err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               len_d     = len;
               src_d     = src_addr;
               dst_d     = dst_addr;
               pat_d     = pattern;
               idx_d     = '0;
               cmd_err_d = (mode == ModeBad) || (len > LenMax);
               if (cmd_err_d || (len == '0)) begin
                  state_d = StDone;
               end else if (mode == ModeFill) begin
                  state_d = StFill;
               end else if (mode == ModeCopy) begin
                  // dst == src+1 would put the pipelined write on the read address every cycle
                  state_d = (dst_addr == src_addr + AddrOne) ? StCopyRd : StCopyP;
               end else begin
                  state_d = StChk;
               end
            end
         end
         StFill: begin
            if (last) state_d = StDone;
            else      idx_d   = idx_q + One;
         end
         StCopyP: begin
            if (last) state_d = StCopyDrain;
            else      idx_d   = idx_q + One;
         end
         StCopyDrain: state_d = StDone;
         StCopyRd:    state_d = StCopyWr;
         StCopyWr: begin
            if (last) begin
               state_d = StDone;
            end else begin
               state_d = StCopyRd;
               idx_d   = idx_q + One;
            end
         end
         StChk: begin
            if (last) state_d = StChkDrain;
            else      idx_d   = idx_q + One;
         end
         StChkDrain: state_d = StDone;
         StDone:     state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // RAM-side outputs are computed from next-state values and registered.
   always_comb begin
      oe1_d     = 1'b0;
      oe2_d     = 1'b0;
      we2_d     = 1'b0;
      copy_wr_d = 1'b0;
      addra_d   = '0;
      addrb_d   = '0;
      rd_addr   = src_d + idx_d[ADDR_WIDTH-1:0];
      wr_addr   = dst_d + idx_d[ADDR_WIDTH-1:0];
      unique case (state_d)
         StFill: begin
            we2_d   = 1'b1;
            addrb_d = wr_addr;
         end
         StCopyP: begin
            oe1_d     = 1'b1;
            addra_d   = rd_addr;
            we2_d     = (idx_d != '0);
            copy_wr_d = we2_d;
            addrb_d   = wr_addr - AddrOne;
         end
         StCopyDrain, StCopyWr: begin
            we2_d     = 1'b1;
            copy_wr_d = 1'b1;
            addrb_d   = wr_addr;
         end
         StCopyRd: begin
            oe1_d   = 1'b1;
            addra_d = rd_addr;
            addrb_d = wr_addr;
         end
         StChk: begin
            oe2_d   = 1'b1;
            addrb_d = wr_addr;
         end
         default: ;
      endcase
      if (!oe1_d) addra_d = ~addrb_d;
      busy_d = (state_d != StIdle) && (state_d != StDone);
      done_d = (state_d == StDone);
      err_d  = done_d && cmd_err_d;
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign mismatch_cnt = cnt_q;
   assign we1          = 1'b0;
   assign oe1          = oe1_q;
   assign addra        = addra_q;
   assign din_a        = '0;
   assign we2          = we2_q;
   assign oe2          = oe2_q;
   assign addrb        = addrb_q;
   // Copy data arrives from the RAM in the write cycle itself, so it bypasses the output register.
   assign din_b        = we2_q ? (copy_wr_q ? dout_a : pat_q) : '0;

endmodule

// File: tb/tb_dpram_xfer_ctrl.sv
// Directed bench for dpram_xfer_ctrl with a behavioural two-port RAM that drops colliding writes.
module tb_dpram_xfer_ctrl;
   localparam int unsigned DW    = 2;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   typedef logic [DW-1:0] mem_t [DEPTH];
   typedef struct {
      logic [1:0]    mode;
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW:0]   len;
      logic [DW-1:0] pat;
      int            exp_cyc;
      int            exp_en;
      logic          exp_err;
      int            exp_cnt;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [1:0]    mode;
   logic [AW-1:0] src_addr, dst_addr, addra, addrb;
   logic [AW:0]   len, mismatch_cnt;
   logic [DW-1:0] pattern, din_a, din_b, dout_a, dout_b;
   logic          busy, done, err, we1, oe1, we2, oe2;

   logic [DW-1:0] mem [DEPTH];
   int checks = 0, errors = 0;
   int collisions = 0, we1_seen = 0, dina_seen = 0;
   vec_t vecs [10];
   mem_t expm;

   always #5 clk = ~clk;

   dpram_xfer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .pattern(pattern), .busy(busy), .done(done), .err(err),
      .mismatch_cnt(mismatch_cnt), .we1(we1), .oe1(oe1), .addra(addra), .din_a(din_a),
      .dout_a(dout_a), .we2(we2), .oe2(oe2), .addrb(addrb), .din_b(din_b), .dout_b(dout_b)
   );

   always @(posedge clk) begin
      dout_a <= oe1 ? mem[addra] : '0;
      dout_b <= oe2 ? mem[addrb] : '0;
      if (we2) begin
         if (addra == addrb) collisions <= collisions + 1;
         else                mem[addrb] <= din_b;
      end
      if (we1) we1_seen <= we1_seen + 1;
      if (din_a != '0) dina_seen <= dina_seen + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic preload(input mem_t v);
      for (int i = 0; i < DEPTH; i++) mem[i] <= v[i];
   endtask

   task automatic cmp_mem(input string tag, input mem_t exp);
      for (int i = 0; i < DEPTH; i++)
         chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(exp[i]));
   endtask

   task automatic run_cmd(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] l, input logic [DW-1:0] p, input int poke,
                          output int cyc, output int en, output logic err_s, output logic busy1,
                          output logic [AW:0] cnt1, output logic [AW:0] cnt_done);
      cyc = 0; en = 0; err_s = 1'b0; busy1 = 1'b0; cnt1 = '0; cnt_done = '0;
      @(negedge clk);
      mode = m; src_addr = s; dst_addr = d; len = l; pattern = p; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 1) begin
            busy1 = busy;
            cnt1  = mismatch_cnt;
         end
         start = (k == poke);
         if (k == poke) mode = 2'b11;
         if (we2 || oe1 || oe2) en++;
         if (done) begin
            cyc      = k;
            err_s    = err;
            cnt_done = mismatch_cnt;
            chk("busy_at_done", 32'(busy), 32'd0);
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic do_cmd(input string tag, input logic [1:0] m, input logic [AW-1:0] s,
                         input logic [AW-1:0] d, input logic [AW:0] l, input logic [DW-1:0] p,
                         input int poke, input int exp_cyc, input int exp_en,
                         input logic exp_err, input int exp_cnt);
      int cyc, en;
      logic err_s, busy1;
      logic [AW:0] cnt1, cnt_done;
      run_cmd(m, s, d, l, p, poke, cyc, en, err_s, busy1, cnt1, cnt_done);
      chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_enable_cycles"}, 32'(en), 32'(exp_en));
      chk({tag, "_err"}, 32'(err_s), 32'(exp_err));
      chk({tag, "_busy_cycle1"}, 32'(busy1), 32'(exp_cyc > 1));
      chk({tag, "_cnt_cleared"}, 32'(cnt1), 32'd0);
      chk({tag, "_mismatch_cnt"}, 32'(cnt_done), 32'(exp_cnt));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mode = '0; src_addr = '0; dst_addr = '0; len = '0;
      pattern = '0;
      for (int i = 0; i < DEPTH; i++) expm[i] = '0;
      preload(expm);
      #1 rst = 1'b1;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cnt", 32'(mismatch_cnt), 32'd0);
      chk("rst_enables", 32'({we1, oe1, we2, oe2}), 32'd0);
      chk("rst_addra", 32'(addra), 32'd15);
      chk("rst_addrb", 32'(addrb), 32'd0);
      chk("rst_din_b", 32'(din_b), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // mode, src, dst, len, pat, done cycle, enable cycles, err, mismatch_cnt
      vecs[0] = '{2'b11, 4'd0,  4'd0, 5'd4,  2'd0, 1, 0, 1'b1, 0};
      vecs[1] = '{2'b00, 4'd0,  4'd0, 5'd17, 2'd1, 1, 0, 1'b1, 0};
      vecs[2] = '{2'b00, 4'd0,  4'd0, 5'd0,  2'd1, 1, 0, 1'b0, 0};
      vecs[3] = '{2'b01, 4'd2,  4'd5, 5'd0,  2'd0, 1, 0, 1'b0, 0};
      vecs[4] = '{2'b10, 4'd0,  4'd0, 5'd17, 2'd0, 1, 0, 1'b1, 0};
      vecs[5] = '{2'b00, 4'd0,  4'd3, 5'd1,  2'd3, 2, 1, 1'b0, 0};
      vecs[6] = '{2'b01, 4'd4,  4'd9, 5'd2,  2'd0, 4, 3, 1'b0, 0};
      vecs[7] = '{2'b01, 4'd15, 4'd0, 5'd2,  2'd0, 5, 4, 1'b0, 0};
      vecs[8] = '{2'b10, 4'd0,  4'd3, 5'd1,  2'd3, 3, 1, 1'b0, 0};
      vecs[9] = '{2'b10, 4'd0,  4'd3, 5'd2,  2'd3, 4, 2, 1'b0, 1};
      foreach (vecs[v])
         do_cmd($sformatf("vec%0d", v), vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len,
                vecs[v].pat, 0, vecs[v].exp_cyc, vecs[v].exp_en, vecs[v].exp_err,
                vecs[v].exp_cnt);

      // FILL wrapping past the top of the RAM
      for (int i = 0; i < DEPTH; i++) expm[i] = DW'(i);
      preload(expm);
      do_cmd("fill_wrap", 2'b00, 4'd0, 4'd14, 5'd4, 2'b10, 0, 5, 4, 1'b0, 0);
      expm[14] = 2'b10; expm[15] = 2'b10; expm[0] = 2'b10; expm[1] = 2'b10;
      cmp_mem("fill_wrap", expm);

      // pipelined COPY into a pre-marked destination
      for (int i = 0; i < DEPTH; i++) expm[i] = (i < 8) ? DW'(i) : 2'b11;
      preload(expm);
      do_cmd("copy_pipe", 2'b01, 4'd0, 4'd8, 5'd8, 2'd0, 0, 10, 9, 1'b0, 0);
      for (int i = 8; i < DEPTH; i++) expm[i] = DW'(i - 8);
      cmp_mem("copy_pipe", expm);

      // overlapping COPY with dst == src+1 must behave as a forward copy
      for (int i = 0; i < DEPTH; i++) expm[i] = '0;
      expm[0] = 2'd1; expm[1] = 2'd2; expm[2] = 2'd3; expm[3] = 2'd0;
      preload(expm);
      do_cmd("copy_serial", 2'b01, 4'd0, 4'd1, 5'd3, 2'd0, 0, 7, 6, 1'b0, 0);
      expm[1] = 2'd1; expm[2] = 2'd1; expm[3] = 2'd1;
      cmp_mem("copy_serial", expm);

      // full-RAM CHECK with one corrupted word
      do_cmd("fill_all", 2'b00, 4'd0, 4'd0, 5'd16, 2'b01, 0, 17, 16, 1'b0, 0);
      mem[5] <= 2'b11;
      do_cmd("check_all", 2'b10, 4'd0, 4'd0, 5'd16, 2'b01, 0, 18, 16, 1'b0, 1);
      @(negedge clk);
      chk("cnt_holds", 32'(mismatch_cnt), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // start during busy (cycle 2, illegal mode) must be ignored
      do_cmd("start_busy", 2'b00, 4'd0, 4'd0, 5'd4, 2'b11, 2, 5, 4, 1'b0, 0);
      chk("start_busy_no_restart", 32'(busy), 32'd0);

      // asynchronous reset in cycle 4 of an 8-word FILL
      for (int i = 0; i < DEPTH; i++) expm[i] = '0;
      preload(expm);
      @(negedge clk);
      mode = 2'b00; dst_addr = 4'd4; len = 5'd8; pattern = 2'b11; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstmid_we2_before", 32'(we2), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rstmid_we2", 32'(we2), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_addra", 32'(addra), 32'd15);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      expm[4] = 2'b11; expm[5] = 2'b11; expm[6] = 2'b11;
      cmp_mem("rstmid", expm);

      chk("write_collisions", 32'(collisions), 32'd0);
      chk("port_a_writes", 32'(we1_seen), 32'd0);
      chk("din_a_nonzero", 32'(dina_seen), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dpram_xfer_ctrl.md
Name: dpram_xfer_ctrl

Overview:
- Sequencing controller for the two-port synchronous RAM (ports A and B, 1-cycle registered read, `dout` zeroed when not reading).
- Runs one of three commands over an address range, modulo RAM depth:
  - FILL: write a constant.
  - COPY: block copy from src to dst.
  - CHECK: compare a range against a constant and count mismatches.
- Sits between a host/test FSM (start/done handshake) and the RAM ports.
- Guarantees the RAM's port-B write is never dropped by an A/B address collision.

Parameters:
- DATA_WIDTH, 2, RAM word width.
- ADDR_WIDTH, 4, RAM address width.
- ADDR_DEPTH, 1<<ADDR_WIDTH, word count. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  command strobe. Sampled only in IDLE.
- mode  in  2  00 FILL, 01 COPY, 10 CHECK, 11 illegal.
- src_addr  in  ADDR_WIDTH  COPY source base.
- dst_addr  in  ADDR_WIDTH  FILL/COPY destination base; CHECK base.
- len  in  ADDR_WIDTH+1  word count, 0..ADDR_DEPTH.
- pattern  in  DATA_WIDTH  FILL data / CHECK expected value.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: illegal mode or len>ADDR_DEPTH.
- mismatch_cnt  out  ADDR_WIDTH+1  CHECK result. Holds until next start.
- we1, oe1  out  1  RAM port A write/read enables.
- addra  out  ADDR_WIDTH  RAM port A address.
- din_a  out  DATA_WIDTH  RAM port A write data. Always 0; port A never writes.
- dout_a  in  DATA_WIDTH  RAM port A read data.
- we2, oe2  out  1  RAM port B write/read enables.
- addrb  out  ADDR_WIDTH  RAM port B address.
- din_b  out  DATA_WIDTH  RAM port B write data.
- dout_b  in  DATA_WIDTH  RAM port B read data.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - All outputs 0, except addra = all-ones so addra != addrb.
  - Reset mid-command stops all RAM writes in the same cycle; words already written remain.
- All RAM-side outputs are registered.
- Invariant: whenever we2=1, addra != addrb. When port A is idle, drive addra = ~addrb.
- Command start:
  - start in IDLE (cycle 0) latches mode, src, dst, len, pattern.
  - Clears mismatch_cnt and sets busy, both at cycle 1.
  - start while busy is ignored.
- len=0, illegal mode, or len>ADDR_DEPTH: no RAM access; done=1 at cycle 1 (err=1 for illegal mode or len>ADDR_DEPTH).
- Addresses: base+i modulo ADDR_DEPTH; wrap-around is legal. Internal index counter is ADDR_WIDTH+1 bits.
- FILL:
  - Cycles 1..len: we2=1, addrb=dst+i, din_b=pattern.
  - done at cycle len+1.
- COPY semantics:
  - Result equals a sequential ascending copy, i=0..len-1, mem[dst+i] <= mem[src+i], including overlap.
  - The hazard case is dst == src+1 (mod depth).
- COPY pipelined (dst != src+1):
  - Cycle i+1: oe1=1, addra=src+i.
  - Cycle i+2: we2=1, addrb=dst+i, din_b=dout_a.
  - The final write cycle has port A idle.
  - done at cycle len+2.
- COPY serial (dst == src+1; the pipelined collision case):
  - States RD, WR alternate.
  - RD: oe1=1, addra=src+i, we2=0.
  - WR: we2=1, addrb=dst+i, din_b=dout_a, oe1=0, addra=~addrb.
  - done at cycle 2*len+1.
- CHECK:
  - Cycles 1..len: oe2=1, we2=0, addrb=dst+i.
  - Cycles 2..len+1: if dout_b != pattern, mismatch_cnt += 1.
  - done at cycle len+2, with final mismatch_cnt valid.
  - Port A idle throughout.
- States: IDLE, FILL, COPY_P, COPY_DRAIN, COPY_RD, COPY_WR, CHK, CHK_DRAIN, DONE.
  - DONE drives done=1 and returns to IDLE.
  - busy=0 in the DONE cycle.
- Back-to-back commands: start may be asserted in the cycle after done; it is accepted.

Test Plan:
- FILL dst=14, len=4, pattern=2'b10 → writes at addresses 14,15,0,1; done at cycle 5; RAM words 2..13 unchanged; err=0.
- COPY non-overlap: preload mem[i]=i[1:0]; src=0, dst=8, len=8 → mem[8..15]=0,1,2,3,0,1,2,3; done at cycle 10; we2 never asserted with addra==addrb.
- COPY hazard: preload mem[0..3]=1,2,3,0; src=0, dst=1, len=3 → serial mode, mem[1..3]=1,1,1 (forward-copy semantics); done at cycle 7.
- CHECK: FILL all 16 words with 2'b01, corrupt mem[5]=2'b11; CHECK dst=0, len=16, pattern=01 → mismatch_cnt=1, done at cycle 18.
- Errors and edge cases:
  - mode=11 → done and err at cycle 1, no RAM enables.
  - len=17 → same result as mode=11.
  - len=0 → done with err=0 at cycle 1.
  - start while busy is ignored.
- Reset mid-FILL (len=8, rst at cycle 4) → all enables 0 asynchronously, busy=0; only words dst..dst+2 written.
